// File: rtl/jtag_hub_router.sv
// Routes a tagged host word stream to/from CHANNELS IP cores; 1-cycle latency each way, readies follow registered state.
// Define JTAG_HUB_ROUTER_TIMEOUT_EN to drop downstream words that wait TIMEOUT_CYCLES without a channel handshake.
module jtag_hub_router #(
  parameter int CHANNELS       = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter logic [CHANNELS*ADDR_WIDTH-1:0] CH_ADDR = {4'hB, 4'h9, 4'hA, 4'hC},
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ce,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] host_dwn_data,
  input  logic                           host_dwn_valid,
  output logic                           host_dwn_ready,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] host_up_data,
  output logic                           host_up_valid,
  input  logic                           host_up_ready,
  output logic [DATA_WIDTH-1:0]          chan_dwn_data,
  output logic [CHANNELS-1:0]            chan_dwn_valid,
  input  logic [CHANNELS-1:0]            chan_dwn_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] chan_up_data,
  input  logic [CHANNELS-1:0]            chan_up_valid,
  output logic [CHANNELS-1:0]            chan_up_ready,
  output logic [7:0]                     drop_count
);

  localparam int W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {EMPTY, HOLD} dstate_t;

  logic [ADDR_WIDTH-1:0] addr_tab [CHANNELS];
  logic [DATA_WIDTH-1:0] up_tab   [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_tab
    assign addr_tab[g] = CH_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign up_tab[g]   = chan_up_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---------------- downstream ----------------
  dstate_t               state_q, state_d;
  logic [IW-1:0]         sel_q, sel_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [7:0]            drop_q, drop_d;
  logic                  drop_inc;

  logic [ADDR_WIDTH-1:0] dwn_addr;
  logic [DATA_WIDTH-1:0] dwn_pay;
  logic                  hit;
  logic [IW-1:0]         hit_idx;
  logic                  sel_ready;
  logic                  dwn_acc;
  logic                  done;

  assign dwn_addr = host_dwn_data[W-1:DATA_WIDTH];
  assign dwn_pay  = host_dwn_data[DATA_WIDTH-1:0];

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!hit && dwn_addr == addr_tab[i]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign sel_ready      = chan_dwn_ready[sel_q];
  assign host_dwn_ready = ce & ~rst & ((state_q == EMPTY) | sel_ready);
  assign dwn_acc        = host_dwn_valid & host_dwn_ready;
  assign done           = ce & (state_q == HOLD) & sel_ready;

`ifdef JTAG_HUB_ROUTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          expired;

  assign expired = ce & (state_q == HOLD) & ~sel_ready & (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tcnt_d = tcnt_q;
    if (ce && state_q == HOLD) tcnt_d = tcnt_q + 1'b1;
    if (dwn_acc && hit)        tcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) tcnt_q <= '0;
    else     tcnt_q <= tcnt_d;
  end
`else
  logic expired;
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    dat_d    = dat_q;
    drop_inc = 1'b0;
    if (done) state_d = EMPTY;
    if (expired) begin
      state_d  = EMPTY;
      drop_inc = 1'b1;
    end
    // A word accepted in the completion cycle reloads the holding register directly.
    if (dwn_acc) begin
      if (hit) begin
        state_d = HOLD;
        sel_d   = hit_idx;
        dat_d   = dwn_pay;
      end else if (dwn_addr != '0) begin
        drop_inc = 1'b1;
      end
    end
    drop_d = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      sel_q   <= '0;
      dat_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    chan_dwn_valid = '0;
    for (int i = 0; i < CHANNELS; i++)
      chan_dwn_valid[i] = (state_q == HOLD) && (sel_q == IW'(i));
  end

  assign chan_dwn_data = dat_q;
  assign drop_count    = drop_q;

  // ---------------- upstream ----------------
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] gnt;
  logic          gnt_vld;
  int            cand;
  logic          up_vld_q, up_vld_d;
  logic [W-1:0]  up_dat_q, up_dat_d;
  logic          up_go;

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    cand    = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = int'(last_q) + 1 + i;
      if (cand >= CHANNELS) cand = cand - CHANNELS;
      if (!gnt_vld && chan_up_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt     = cand[IW-1:0];
      end
    end
  end

  assign up_go = ce & ~rst & (~up_vld_q | host_up_ready) & gnt_vld;

  always_comb begin
    chan_up_ready = '0;
    for (int i = 0; i < CHANNELS; i++)
      chan_up_ready[i] = up_go && (gnt == IW'(i));
  end

  always_comb begin
    up_vld_d = up_vld_q;
    up_dat_d = up_dat_q;
    last_d   = last_q;
    if (up_go) begin
      up_vld_d = 1'b1;
      up_dat_d = {addr_tab[gnt], up_tab[gnt]};
      last_d   = gnt;
    end else if (ce && host_up_ready) begin
      up_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_vld_q <= 1'b0;
      up_dat_q <= '0;
      last_q   <= IW'(CHANNELS - 1);
    end else begin
      up_vld_q <= up_vld_d;
      up_dat_q <= up_dat_d;
      last_q   <= last_d;
    end
  end

  assign host_up_valid = up_vld_q;
  assign host_up_data  = up_dat_q;

endmodule

// File: tb/tb_jtag_hub_router.sv
// Directed-vector bench for jtag_hub_router with the default 4-channel address map.
module tb_jtag_hub_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [11:0] host_dwn_data;
  logic        host_dwn_valid;
  logic        host_dwn_ready;
  logic [11:0] host_up_data;
  logic        host_up_valid;
  logic        host_up_ready;
  logic [7:0]  chan_dwn_data;
  logic [3:0]  chan_dwn_valid;
  logic [3:0]  chan_dwn_ready;
  logic [31:0] chan_up_data;
  logic [3:0]  chan_up_valid;
  logic [3:0]  chan_up_ready;
  logic [7:0]  drop_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jtag_hub_router #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .host_dwn_data(host_dwn_data), .host_dwn_valid(host_dwn_valid), .host_dwn_ready(host_dwn_ready),
    .host_up_data(host_up_data), .host_up_valid(host_up_valid), .host_up_ready(host_up_ready),
    .chan_dwn_data(chan_dwn_data), .chan_dwn_valid(chan_dwn_valid), .chan_dwn_ready(chan_dwn_ready),
    .chan_up_data(chan_up_data), .chan_up_valid(chan_up_valid), .chan_up_ready(chan_up_ready),
    .drop_count(drop_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ce = 1'b1;
    host_dwn_data = '0; host_dwn_valid = 1'b0; host_up_ready = 1'b0;
    chan_dwn_ready = '0; chan_up_data = '0; chan_up_valid = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1;
    host_dwn_data = '0; host_dwn_valid = 1'b0; host_up_ready = 1'b1;
    chan_dwn_ready = '0; chan_up_data = '0; chan_up_valid = '0;
    tick(); tick();
    tests++; if (host_dwn_ready !== 1'b0) begin fails++; $display("FAIL rst_dwn_ready got %b exp 0", host_dwn_ready); end
    tests++; if (chan_dwn_valid !== 4'b0000) begin fails++; $display("FAIL rst_dwn_valid got %b exp 0000", chan_dwn_valid); end
    tests++; if (host_up_valid !== 1'b0) begin fails++; $display("FAIL rst_up_valid got %b exp 0", host_up_valid); end
    tests++; if (chan_dwn_data !== 8'h00) begin fails++; $display("FAIL rst_dwn_data got %h exp 00", chan_dwn_data); end
    tests++; if (host_up_data !== 12'h000) begin fails++; $display("FAIL rst_up_data got %h exp 000", host_up_data); end
    tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL rst_drop got %0d exp 0", drop_count); end
    rst = 1'b0;
    #1;
    tests++; if (host_dwn_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready got %b exp 1", host_dwn_ready); end
    host_up_ready = 1'b0;
  endtask

  task automatic test_single();
    host_dwn_data = 12'hC55; host_dwn_valid = 1'b1;
    tick();
    host_dwn_valid = 1'b0;
    tests++; if (chan_dwn_valid !== 4'b0001) begin fails++; $display("FAIL single_vld got %b exp 0001", chan_dwn_valid); end
    tests++; if (chan_dwn_data !== 8'h55) begin fails++; $display("FAIL single_data got %h exp 55", chan_dwn_data); end
    tests++; if (host_dwn_ready !== 1'b0) begin fails++; $display("FAIL single_hold_ready got %b exp 0", host_dwn_ready); end
    chan_dwn_ready = 4'b0001;
    #1;
    tests++; if (host_dwn_ready !== 1'b1) begin fails++; $display("FAIL single_pass_ready got %b exp 1", host_dwn_ready); end
    tick();
    tests++; if (chan_dwn_valid !== 4'b0000) begin fails++; $display("FAIL single_clear got %b exp 0000", chan_dwn_valid); end
    chan_dwn_ready = '0;
  endtask

  task automatic test_back_to_back();
    chan_dwn_ready = 4'b1100;
    host_dwn_data = 12'h9AA; host_dwn_valid = 1'b1;
    tick();
    tests++; if (chan_dwn_valid !== 4'b0100) begin fails++; $display("FAIL b2b_vld0 got %b exp 0100", chan_dwn_valid); end
    tests++; if (chan_dwn_data !== 8'hAA) begin fails++; $display("FAIL b2b_data0 got %h exp AA", chan_dwn_data); end
    tests++; if (host_dwn_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready0 got %b exp 1", host_dwn_ready); end
    host_dwn_data = 12'hB01;
    tick();
    tests++; if (chan_dwn_valid !== 4'b1000) begin fails++; $display("FAIL b2b_vld1 got %b exp 1000", chan_dwn_valid); end
    tests++; if (chan_dwn_data !== 8'h01) begin fails++; $display("FAIL b2b_data1 got %h exp 01", chan_dwn_data); end
    tests++; if (host_dwn_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready1 got %b exp 1", host_dwn_ready); end
    host_dwn_valid = 1'b0;
    tick();
    tests++; if (chan_dwn_valid !== 4'b0000) begin fails++; $display("FAIL b2b_clear got %b exp 0000", chan_dwn_valid); end
    chan_dwn_ready = '0;
  endtask

  task automatic test_drop();
    host_dwn_data = 12'h0FF; host_dwn_valid = 1'b1;
    tick();
    tests++; if (chan_dwn_valid !== 4'b0000) begin fails++; $display("FAIL nop_vld got %b exp 0000", chan_dwn_valid); end
    tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL nop_drop got %0d exp 0", drop_count); end
    host_dwn_data = 12'h7FF;
    tick();
    tests++; if (chan_dwn_valid !== 4'b0000) begin fails++; $display("FAIL bad_vld got %b exp 0000", chan_dwn_valid); end
    tests++; if (drop_count !== 8'd1) begin fails++; $display("FAIL bad_drop got %0d exp 1", drop_count); end
    repeat (300) tick();
    host_dwn_valid = 1'b0;
    tests++; if (drop_count !== 8'd255) begin fails++; $display("FAIL drop_sat got %0d exp 255", drop_count); end
  endtask

  task automatic test_round_robin();
    logic [11:0] exp_up [4];
    exp_up[0] = 12'hC10; exp_up[1] = 12'hA11; exp_up[2] = 12'h912; exp_up[3] = 12'hB13;
    do_reset();
    chan_up_data = {8'h13, 8'h12, 8'h11, 8'h10};
    chan_up_valid = 4'b1111; host_up_ready = 1'b1;
    #1;
    tests++; if (chan_up_ready !== 4'b0001) begin fails++; $display("FAIL rr_first_grant got %b exp 0001", chan_up_ready); end
    for (int k = 0; k < 8; k++) begin
      tick();
      tests++; if (host_up_data !== exp_up[k % 4] || host_up_valid !== 1'b1) begin
        fails++; $display("FAIL rr_seq%0d got %h/%b exp %h/1", k, host_up_data, host_up_valid, exp_up[k % 4]);
      end
    end
  endtask

  task automatic test_stall();
    host_up_ready = 1'b0;
    #1;
    tests++; if (chan_up_ready !== 4'b0000) begin fails++; $display("FAIL stall_ready0 got %b exp 0000", chan_up_ready); end
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++; if (host_up_data !== 12'hB13 || chan_up_ready !== 4'b0000) begin
        fails++; $display("FAIL stall_cyc%0d got %h/%b exp B13/0000", k, host_up_data, chan_up_ready);
      end
    end
    host_up_ready = 1'b1;
    #1;
    tests++; if (chan_up_ready !== 4'b0001) begin fails++; $display("FAIL stall_release got %b exp 0001", chan_up_ready); end
    tick();
    tests++; if (host_up_data !== 12'hC10) begin fails++; $display("FAIL stall_resume got %h exp C10", host_up_data); end
  endtask

  task automatic test_ce();
    chan_up_valid = 4'b0000; host_up_ready = 1'b0;
    host_dwn_data = 12'hA33; host_dwn_valid = 1'b1;
    tick();
    tests++; if (chan_dwn_valid !== 4'b0010) begin fails++; $display("FAIL ce_setup got %b exp 0010", chan_dwn_valid); end
    ce = 1'b0;
    host_dwn_data = 12'hC55; chan_dwn_ready = 4'b0010;
    chan_up_valid = 4'b1111; host_up_ready = 1'b1;
    #1;
    tests++; if (host_dwn_ready !== 1'b0) begin fails++; $display("FAIL ce_dwn_ready got %b exp 0", host_dwn_ready); end
    tests++; if (chan_up_ready !== 4'b0000) begin fails++; $display("FAIL ce_up_ready got %b exp 0000", chan_up_ready); end
    repeat (3) tick();
    tests++; if (chan_dwn_valid !== 4'b0010) begin fails++; $display("FAIL ce_dwn_hold got %b exp 0010", chan_dwn_valid); end
    tests++; if (host_up_data !== 12'hC10 || host_up_valid !== 1'b1) begin
      fails++; $display("FAIL ce_up_hold got %h/%b exp C10/1", host_up_data, host_up_valid);
    end
    ce = 1'b1; host_dwn_valid = 1'b0;
    tick();
    tests++; if (chan_dwn_valid !== 4'b0000) begin fails++; $display("FAIL ce_resume_dwn got %b exp 0000", chan_dwn_valid); end
    tests++; if (host_up_data !== 12'hA11) begin fails++; $display("FAIL ce_resume_up got %h exp A11", host_up_data); end
    tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL ce_drop got %0d exp 0", drop_count); end
    chan_up_valid = '0; host_up_ready = 1'b0; chan_dwn_ready = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    host_dwn_data = 12'hA33; host_dwn_valid = 1'b1;
    tick();
    host_dwn_valid = 1'b0;
    tests++; if (chan_dwn_valid !== 4'b0010) begin fails++; $display("FAIL to_load got %b exp 0010", chan_dwn_valid); end
`ifdef JTAG_HUB_ROUTER_TIMEOUT_EN
    repeat (15) tick();
    tests++; if (chan_dwn_valid !== 4'b0010) begin fails++; $display("FAIL to_before got %b exp 0010", chan_dwn_valid); end
    tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL to_before_drop got %0d exp 0", drop_count); end
    tick();
    tests++; if (chan_dwn_valid !== 4'b0000) begin fails++; $display("FAIL to_expire got %b exp 0000", chan_dwn_valid); end
    tests++; if (drop_count !== 8'd1) begin fails++; $display("FAIL to_drop got %0d exp 1", drop_count); end
`else
    repeat (1000) tick();
    tests++; if (chan_dwn_valid !== 4'b0010) begin fails++; $display("FAIL hold_forever got %b exp 0010", chan_dwn_valid); end
    tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL hold_drop got %0d exp 0", drop_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_round_robin();
    test_stall();
    test_ce();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtag_hub_router.md
# jtag_hub_router

Parametrised, synthesizable channel router between one host-side tagged word stream and `CHANNELS` IP channels (LA, IOView, GDB, WFG, …). It is the successor of the fixed 4-channel hub:

- channel count, data width and channel address codes are parameters;
- the upstream direction is round-robin arbitrated;
- downstream words carrying unknown addresses are counted.

It sits between the JTAG transport (TAP shift logic) and the IP cores.

## Interface
Parameters:
- `CHANNELS`, 4, number of IP channels, 1..8
- `DATA_WIDTH`, 8, payload bits per word
- `ADDR_WIDTH`, 4, channel address field width
- `CH_ADDR`, {4'hB,4'h9,4'hA,4'hC}, packed `CHANNELS*ADDR_WIDTH` address codes; slice i is channel i; codes must be distinct and nonzero
- `TIMEOUT_CYCLES`, 1024, downstream delivery timeout; used only with `JTAG_HUB_ROUTER_TIMEOUT_EN`

Ports:
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `ce` in 1: clock enable
- `host_dwn_data` in `ADDR_WIDTH+DATA_WIDTH`: {addr, payload}
- `host_dwn_valid` in 1
- `host_dwn_ready` out 1
- `host_up_data` out `ADDR_WIDTH+DATA_WIDTH`: {CH_ADDR[k], payload}
- `host_up_valid` out 1
- `host_up_ready` in 1
- `chan_dwn_data` out `DATA_WIDTH`: shared by all channels
- `chan_dwn_valid` out `CHANNELS`: one-hot or zero
- `chan_dwn_ready` in `CHANNELS`
- `chan_up_data` in `CHANNELS*DATA_WIDTH`: slice i belongs to channel i
- `chan_up_valid` in `CHANNELS`
- `chan_up_ready` out `CHANNELS`
- `drop_count` out 8: saturating count of dropped downstream words

## Operation
Downstream path: a one-entry holding register, states EMPTY / HOLD.
- EMPTY: `host_dwn_ready=ce`. When a host word is accepted:
  - addr matches `CH_ADDR` slice k: go to HOLD, latch payload, `chan_dwn_valid[k]=1`.
  - addr == 0: NOP, discarded, not counted, stay EMPTY.
  - any other addr: discarded, `drop_count++` (saturates at 255), stay EMPTY.
- HOLD: `host_dwn_ready = ce & chan_dwn_ready[k]`.
  - On `chan_dwn_ready[k]` the word completes.
  - In the same cycle, a new host word may be accepted and decoded as above (back-to-back throughput of 1 word/cycle).
  - If no new host word is accepted, return to EMPTY.
- `chan_dwn_valid` is never deasserted without a handshake, except by reset or a timeout (see Configuration).

Upstream path: output register plus round-robin arbiter.
- The arbiter pointer `last` holds the most recently granted channel. The grant goes to the first valid channel scanning from `last+1` upward, with wrap-around.
- `chan_up_ready[g] = ce & (~host_up_valid | host_up_ready)` for the granted channel g only; all other channels see 0.
- Handshake on channel g: load `{CH_ADDR[g], chan_up_data[g]}`, set `host_up_valid`, set `last=g`.
- `host_up_valid` clears on `host_up_ready` unless it is reloaded in the same cycle.
- `ce=0`: no state changes; `host_dwn_ready=0` and all `chan_up_ready=0`; all valids and data outputs hold.

## Timing
- Reset values:
  - `host_dwn_ready=0` during reset.
  - `chan_dwn_valid=0`, `host_up_valid=0`, `chan_dwn_data=0`, `host_up_data=0`.
  - `drop_count=0`, `last=CHANNELS-1` (so channel 0 has first priority).
  - Reset mid-transfer discards the held words.
- Downstream latency: host word accepted at edge N → `chan_dwn_valid[k]` high after edge N.
- Upstream latency: channel handshake at edge N → `host_up_valid` high after edge N.
- The host-side readies are combinational from the registered state and channel readies. There is no combinational path from `host_dwn_valid` to any output.
- Fairness: with all channels continuously valid and the host always ready, channels are granted in order 0,1,…,`CHANNELS-1`,0, one per cycle.

## Configuration
- `JTAG_HUB_ROUTER_TIMEOUT_EN` defined:
  - A counter runs while in HOLD and restarts on each new held word.
  - If `TIMEOUT_CYCLES` consecutive `ce` cycles pass without `chan_dwn_ready[k]`, the word is dropped, `chan_dwn_valid` clears and `drop_count++`.
- Undefined: no counter; HOLD persists indefinitely (legacy behaviour).

## Test plan
- Reset, then host sends 0xC55 → `chan_dwn_valid=4'b0001`, `chan_dwn_data=8'h55`. Channel 0 ready one cycle later → valid clears.
- Host sends 0x9AA, 0xB01 back-to-back while channels 2 and 3 hold ready=1 → 2 consecutive delivery cycles; `host_dwn_ready` stays 1.
- Host sends 0x0FF, then 0x7FF → neither is delivered; `drop_count=1`. Send 0x7FF 300 times → `drop_count=255`.
- All four `chan_up_valid=1` with data 0x10..0x13, host always ready → `host_up_data` sequence 0xC10, 0xA11, 0x912, 0xB13, repeating.
- `host_up_ready=0` for 5 cycles with channels valid → `host_up_data` stable, all `chan_up_ready=0`; `ce=0` freezes both paths.
- With `JTAG_HUB_ROUTER_TIMEOUT_EN` and `TIMEOUT_CYCLES=16`: 0xA33 sent, channel 1 never ready → valid clears after 16 cycles and `drop_count` increments; without the macro, valid still high after 1000 cycles.
